spi_tx_arbiter: RTL

//   Shares the single SPI byte transmitter between NREQ requesters (cipher output, key-exchange, status).

---
 rtl/spi_tx_arbiter.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/spi_tx_arbiter.sv
// spi_tx_arbiter: round-robin packet arbiter feeding one SPI byte transmitter.
// Define SPI_TX_HDR_EN to prefix every packet with a header byte {4'hA, 1'b0, owner}.
module spi_tx_arbiter #(
    parameter int NREQ       = 4,
    parameter int GAP_CYCLES = 2,
    parameter int MAX_BYTES  = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [8*NREQ-1:0]   req_data,
    input  logic [NREQ-1:0]     req_last,
    output logic [NREQ-1:0]     req_ready,
    output logic [7:0]          tx_data,
    output logic                tx_hold,
    input  logic                tx_done,
    output logic [NREQ-1:0]     grant,
    output logic                busy,
    output logic                trunc_err
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(MAX_BYTES + 1);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [IW:0] NREQ_W = (IW + 1)'(NREQ);

    typedef enum logic [2:0] {
        IDLE, ARB, HDR, LOAD, SEND, GAP
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [CW-1:0]   byte_cnt_q, byte_cnt_d;
    logic [GW-1:0]   gap_cnt_q, gap_cnt_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic            tx_hold_q, tx_hold_d;
    logic            last_q, last_d;
    logic            trunc_err_q, trunc_err_d;
`ifdef SPI_TX_HDR_EN
    logic            hdr_q, hdr_d;
`endif

    logic [NREQ-1:0] rot;
    logic            win_found;
    logic [IW-1:0]   win_off;
    logic [IW:0]     win_sum;
    logic [IW-1:0]   win_idx;
    logic            lane_valid;
    logic            lane_last;
    logic [7:0]      lane_byte;

    // Rotate requests so bit 0 is rr_ptr; first set bit is the winner offset
    always_comb begin
        rot       = NREQ'({req_valid, req_valid} >> rr_ptr_q);
        win_found = 1'b0;
        win_off   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!win_found && rot[i]) begin
                win_found = 1'b1;
                win_off   = IW'(i);
            end
        end
        win_sum = {1'b0, rr_ptr_q} + {1'b0, win_off};
        if (win_sum >= NREQ_W) begin
            win_sum = win_sum - NREQ_W;
        end
        win_idx = win_sum[IW-1:0];
    end

    always_comb begin
        lane_valid = 1'b0;
        lane_last  = 1'b0;
        lane_byte  = 8'h00;
        for (int i = 0; i < NREQ; i++) begin
            if (owner_q == IW'(i)) begin
                lane_valid = req_valid[i];
                lane_last  = req_last[i];
                lane_byte  = req_data[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        owner_d     = owner_q;
        byte_cnt_d  = byte_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        grant_d     = grant_q;
        tx_data_d   = tx_data_q;
        tx_hold_d   = tx_hold_q;
        last_d      = last_q;
        trunc_err_d = 1'b0;
`ifdef SPI_TX_HDR_EN
        hdr_d       = hdr_q;
`endif
        case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    state_d = ARB;
                end
            end
            ARB: begin
                if (win_found) begin
                    owner_d    = win_idx;
                    grant_d    = NREQ'(1) << win_idx;
                    rr_ptr_d   = (win_idx == IW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
                    byte_cnt_d = '0;
`ifdef SPI_TX_HDR_EN
                    state_d    = HDR;
`else
                    state_d    = LOAD;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
`ifdef SPI_TX_HDR_EN
            HDR: begin
                tx_data_d = {4'hA, 1'b0, 3'(owner_q)};
                tx_hold_d = 1'b0;
                hdr_d     = 1'b1;
                state_d   = SEND;
            end
`endif
            LOAD: begin
                if (lane_valid) begin
                    tx_data_d  = lane_byte;
                    tx_hold_d  = 1'b0;
                    last_d     = lane_last;
                    byte_cnt_d = byte_cnt_q + 1'b1;
                    state_d    = SEND;
                end
            end
            SEND: begin
                if (tx_done) begin
                    tx_hold_d = 1'b1;
`ifdef SPI_TX_HDR_EN
                    if (hdr_q) begin
                        hdr_d   = 1'b0;
                        state_d = LOAD;
                    end else
`endif
                    if (last_q || byte_cnt_q == CW'(MAX_BYTES)) begin
                        grant_d     = '0;
                        gap_cnt_d   = '0;
                        trunc_err_d = !last_q;
                        state_d     = GAP;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            GAP: begin
                if (gap_cnt_q == GW'(GAP_CYCLES - 1)) begin
                    state_d = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            byte_cnt_q  <= '0;
            gap_cnt_q   <= '0;
            grant_q     <= '0;
            tx_data_q   <= 8'h00;
            tx_hold_q   <= 1'b1;
            last_q      <= 1'b0;
            trunc_err_q <= 1'b0;
`ifdef SPI_TX_HDR_EN
            hdr_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            owner_q     <= owner_d;
            byte_cnt_q  <= byte_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            grant_q     <= grant_d;
            tx_data_q   <= tx_data_d;
            tx_hold_q   <= tx_hold_d;
            last_q      <= last_d;
            trunc_err_q <= trunc_err_d;
`ifdef SPI_TX_HDR_EN
            hdr_q       <= hdr_d;
`endif
        end
    end

    // Ready is the consume strobe: only the owner, only while LOAD sees its byte
    assign req_ready = (state_q == LOAD && lane_valid) ? grant_q : '0;
    assign tx_data   = tx_data_q;
    assign tx_hold   = tx_hold_q;
    assign grant     = grant_q;
    assign busy      = (state_q != IDLE);
    assign trunc_err = trunc_err_q;

endmodule
